rv32_regfile_mp: RTL and testbench

- Parametrised multi-port integer register file for the rv32im core; generalises the 2-read/1-write regfile.
- Adds a configurable number of read and write ports, write-to-read bypass, and a per-register busy scoreboard for dual-issue / multi-cycle (MUL/DIV) writeback.
- Sits between decode/issue (reads, busy checks) and writeback (writes, busy clears).

---
 rtl/rv32_regfile_mp.sv | 119 +++++++++++
 tb/tb_rv32_regfile_mp.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_regfile_mp.sv
// Multi-port integer register file for the rv32im core with write-to-read bypass
// and a per-register busy scoreboard for dual-issue and multi-cycle writeback.
module rv32_regfile_mp #(
    parameter int XLEN     = 32,
    parameter int AW       = 5,
    parameter int NRP      = 3,
    parameter int NWP      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NWP-1:0]        we_i,
    input  logic [NWP*AW-1:0]     rd_addr_i,
    input  logic [NWP*XLEN-1:0]   val_rd_i,
    input  logic [NRP*AW-1:0]     rs_addr_i,
    output logic [NRP*XLEN-1:0]   val_rs_o,
    input  logic                  sb_set_i,
    input  logic [AW-1:0]         sb_set_addr_i,
    output logic [NRP-1:0]        busy_o,
    output logic [(2**AW)-1:0]    busy_vec_o
);

    localparam int NREG = 2**AW;

    logic [XLEN-1:0] regs    [NREG];
    logic [XLEN-1:0] wr_data [NREG];
    logic [NREG-1:0] wr_hit;
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;
    logic [AW-1:0]   raddr   [NRP];

    for (genvar p = 0; p < NRP; p++) begin : g_raddr
        assign raddr[p] = rs_addr_i[p*AW +: AW];
    end

    // Per-register write select; ports are scanned low to high so the highest
    // enabled port with a matching address overrides earlier ones.
    always_comb begin
        wr_hit = '0;
        for (int r = 0; r < NREG; r++) begin
            wr_data[r] = regs[r];
        end
        for (int k = 0; k < NWP; k++) begin
            if (we_i[k]) begin
                for (int r = 0; r < NREG; r++) begin
                    if (rd_addr_i[k*AW +: AW] == AW'(r)) begin
                        wr_hit[r]  = 1'b1;
                        wr_data[r] = val_rd_i[k*XLEN +: XLEN];
                    end
                end
            end
        end
        if (ZERO_REG != 0) begin
            wr_hit[0]  = 1'b0;
            wr_data[0] = '0;
        end
    end

    // A new producer issuing on the same register as a retiring one keeps it busy.
    always_comb begin
        busy_nxt = busy & ~wr_hit;
        if (sb_set_i) begin
            for (int r = 0; r < NREG; r++) begin
                if (sb_set_addr_i == AW'(r)) begin
                    busy_nxt[r] = 1'b1;
                end
            end
        end
        if (ZERO_REG != 0) begin
            busy_nxt[0] = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int r = 0; r < NREG; r++) begin
                regs[r] <= '0;
            end
            busy <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if (wr_hit[r]) begin
                    regs[r] <= wr_data[r];
                end
            end
            busy <= busy_nxt;
        end
    end

    always_comb begin
        val_rs_o = '0;
        busy_o   = '0;
        for (int p = 0; p < NRP; p++) begin
            val_rs_o[p*XLEN +: XLEN] = regs[raddr[p]];
            busy_o[p]                = busy[raddr[p]];
            if (BYPASS != 0) begin
                for (int k = 0; k < NWP; k++) begin
                    if (we_i[k] && (rd_addr_i[k*AW +: AW] == raddr[p])) begin
                        val_rs_o[p*XLEN +: XLEN] = val_rd_i[k*XLEN +: XLEN];
                        busy_o[p]                = 1'b0;
                    end
                end
            end
            if ((ZERO_REG != 0) && (raddr[p] == '0)) begin
                val_rs_o[p*XLEN +: XLEN] = '0;
                busy_o[p]                = 1'b0;
            end
            // Bypass paths are combinational, so reset must mask them explicitly.
            if (rst_i) begin
                val_rs_o[p*XLEN +: XLEN] = '0;
                busy_o[p]                = 1'b0;
            end
        end
    end

    assign busy_vec_o = rst_i ? '0 : busy;

endmodule

// File: tb/tb_rv32_regfile_mp.sv
// Directed bench for rv32_regfile_mp: one bypassing instance and one without
// bypass share the same stimulus so forwarding can be compared side by side.
module tb_rv32_regfile_mp;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [1:0]  we_i;
    logic [9:0]  rd_addr_i;
    logic [63:0] val_rd_i;
    logic [14:0] rs_addr_i;
    logic        sb_set_i;
    logic [4:0]  sb_set_addr_i;
    logic [95:0] val_rs_o, val_rs_nb;
    logic [2:0]  busy_o, busy_nb;
    logic [31:0] busy_vec_o, busy_vec_nb;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    rv32_regfile_mp #(.BYPASS(1)) dut (
        .clk_i(clk), .rst_i(rst_i), .we_i(we_i), .rd_addr_i(rd_addr_i),
        .val_rd_i(val_rd_i), .rs_addr_i(rs_addr_i), .val_rs_o(val_rs_o),
        .sb_set_i(sb_set_i), .sb_set_addr_i(sb_set_addr_i),
        .busy_o(busy_o), .busy_vec_o(busy_vec_o)
    );

    rv32_regfile_mp #(.BYPASS(0)) dut_nb (
        .clk_i(clk), .rst_i(rst_i), .we_i(we_i), .rd_addr_i(rd_addr_i),
        .val_rd_i(val_rd_i), .rs_addr_i(rs_addr_i), .val_rs_o(val_rs_nb),
        .sb_set_i(sb_set_i), .sb_set_addr_i(sb_set_addr_i),
        .busy_o(busy_nb), .busy_vec_o(busy_vec_nb)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we_i     = '0;
        sb_set_i = 1'b0;
    endtask

    task automatic wr(input int k, input logic [4:0] a, input logic [31:0] d);
        we_i[k]            = 1'b1;
        rd_addr_i[k*5 +: 5] = a;
        val_rd_i[k*32 +: 32] = d;
    endtask

    task automatic set_rs_all(input logic [4:0] a);
        rs_addr_i = {a, a, a};
    endtask

    function automatic logic [31:0] rs(input int p);
        return val_rs_o[p*32 +: 32];
    endfunction

    function automatic logic [31:0] rs_nb(input int p);
        return val_rs_nb[p*32 +: 32];
    endfunction

    task automatic test_reset();
        rst_i = 1'b1;
        idle();
        rd_addr_i = '0; val_rd_i = '0; rs_addr_i = '0; sb_set_addr_i = '0;
        tick();
        tests++;
        if (val_rs_o !== 96'h0 || busy_vec_o !== 32'h0) begin
            fails++;
            $display("FAIL reset_hold rs=%h busy_vec=%h expected 0/0", val_rs_o, busy_vec_o);
        end
        rst_i = 1'b0;
        tick();
        wr(0, 5'd7, 32'hDEAD_BEEF);
        tick();
        idle();
        set_rs_all(5'd7);
        #1;
        tests++;
        if (rs(0) !== 32'hDEAD_BEEF) begin
            fails++;
            $display("FAIL reset_prewrite got %h expected deadbeef", rs(0));
        end
        rst_i = 1'b1;
        #1;
        tests++;
        if (rs(0) !== 32'h0) begin
            fails++;
            $display("FAIL reset_async got %h expected 0", rs(0));
        end
        rst_i = 1'b0;
        #1;
        for (int a = 0; a < 32; a++) begin
            set_rs_all(5'(a));
            #1;
            tests++;
            if (val_rs_o !== 96'h0) begin
                fails++;
                $display("FAIL reset_clear addr=%0d got %h expected 0", a, val_rs_o);
            end
        end
        tests++;
        if (busy_vec_o !== 32'h0) begin
            fails++;
            $display("FAIL reset_busy got %h expected 0", busy_vec_o);
        end
    endtask

    task automatic test_fill();
        logic [31:0] exp;
        for (int i = 0; i < 32; i++) begin
            tick();
            idle();
            wr(0, 5'(i), 32'((i + 1) * 12));
        end
        tick();
        idle();
        for (int i = 0; i < 32; i++) begin
            set_rs_all(5'(i));
            #1;
            exp = (i == 0) ? 32'd0 : 32'((i + 1) * 12);
            for (int p = 0; p < 3; p++) begin
                tests++;
                if (rs(p) !== exp) begin
                    fails++;
                    $display("FAIL fill reg=%0d port=%0d got %0d expected %0d", i, p, rs(p), exp);
                end
            end
        end
        set_rs_all(5'd31);
        #1;
        tests++;
        if (rs(2) !== 32'd384) begin
            fails++;
            $display("FAIL fill_r31 got %0d expected 384", rs(2));
        end
    endtask

    task automatic test_collision();
        tick();
        idle();
        wr(0, 5'd3, 32'd546);
        wr(1, 5'd3, 32'd777);
        tick();
        idle();
        wr(0, 5'd4, 32'd11);
        wr(1, 5'd5, 32'd22);
        tick();
        idle();
        rs_addr_i = {5'd5, 5'd4, 5'd3};
        #1;
        tests++;
        if (rs_nb(0) !== 32'd777 || rs(0) !== 32'd777) begin
            fails++;
            $display("FAIL collision_same got %0d/%0d expected 777", rs(0), rs_nb(0));
        end
        tests++;
        if (rs(1) !== 32'd11 || rs(2) !== 32'd22) begin
            fails++;
            $display("FAIL collision_diff got %0d/%0d expected 11/22", rs(1), rs(2));
        end
    endtask

    task automatic test_bypass();
        tick();
        idle();
        rst_i = 1'b1;
        #1;
        rst_i = 1'b0;
        tick();
        rs_addr_i = {5'd0, 5'd9, 5'd0};
        wr(0, 5'd9, 32'h1234);
        #1;
        tests++;
        if (rs(1) !== 32'h1234) begin
            fails++;
            $display("FAIL bypass_fwd got %h expected 1234", rs(1));
        end
        tests++;
        if (rs_nb(1) !== 32'h0) begin
            fails++;
            $display("FAIL nobypass_old got %h expected 0", rs_nb(1));
        end
        tick();
        idle();
        #1;
        tests++;
        if (rs_nb(1) !== 32'h1234) begin
            fails++;
            $display("FAIL nobypass_next got %h expected 1234", rs_nb(1));
        end
    endtask

    task automatic test_scoreboard();
        tick();
        idle();
        rs_addr_i = {5'd12, 5'd0, 5'd0};
        sb_set_i = 1'b1;
        sb_set_addr_i = 5'd12;
        #1;
        tests++;
        if (busy_vec_o[12] !== 1'b0) begin
            fails++;
            $display("FAIL sb_latency got %b expected 0", busy_vec_o[12]);
        end
        tick();
        idle();
        #1;
        tests++;
        if (busy_vec_o !== 32'h0000_1000 || busy_o !== 3'b100) begin
            fails++;
            $display("FAIL sb_set vec=%h busy=%b expected 00001000/100", busy_vec_o, busy_o);
        end
        wr(1, 5'd12, 32'd5);
        #1;
        tests++;
        if (busy_o[2] !== 1'b0 || busy_nb[2] !== 1'b1) begin
            fails++;
            $display("FAIL sb_write_cycle got %b/%b expected 0/1", busy_o[2], busy_nb[2]);
        end
        tick();
        idle();
        #1;
        tests++;
        if (busy_vec_o[12] !== 1'b0 || busy_o[2] !== 1'b0) begin
            fails++;
            $display("FAIL sb_clear got %b/%b expected 0/0", busy_vec_o[12], busy_o[2]);
        end
        sb_set_i = 1'b1;
        sb_set_addr_i = 5'd12;
        wr(0, 5'd12, 32'd6);
        tick();
        idle();
        #1;
        tests++;
        if (busy_vec_o[12] !== 1'b1 || rs(2) !== 32'd6) begin
            fails++;
            $display("FAIL sb_set_wins got busy=%b val=%0d expected 1/6", busy_vec_o[12], rs(2));
        end
    endtask

    task automatic test_x0();
        tick();
        idle();
        wr(0, 5'd0, 32'd654);
        wr(1, 5'd0, 32'd654);
        sb_set_i = 1'b1;
        sb_set_addr_i = 5'd0;
        set_rs_all(5'd0);
        #1;
        tests++;
        if (val_rs_o !== 96'h0 || busy_o !== 3'b000) begin
            fails++;
            $display("FAIL x0_same_cycle got %h/%b expected 0/000", val_rs_o, busy_o);
        end
        tick();
        idle();
        #1;
        tests++;
        if (val_rs_o !== 96'h0 || val_rs_nb !== 96'h0 || busy_vec_o[0] !== 1'b0) begin
            fails++;
            $display("FAIL x0_after got %h/%h busy0=%b expected 0/0/0", val_rs_o, val_rs_nb, busy_vec_o[0]);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_collision();
        test_bypass();
        test_scoreboard();
        test_x0();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout tests=%0d expected completion", tests);
        $fatal(1, "timeout");
    end

endmodule
